// File: rtl/sra_pkg.sv
// Shared types and constants for the scan response analyzer: FSM states and MISR polynomial/seed.
package sra_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } sra_state_e;

    // Feedback taps on bits 7,5,4,3 of the 8-bit signature.
    localparam logic [7:0] MISR_TAPS = 8'hB8;
    localparam logic [7:0] MISR_SEED = 8'h00;

endpackage

// File: rtl/sra_misr.sv
// Single-input signature register: shifts left, feeding back the tap parity XOR the serial input.
module sra_misr
    import sra_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            sig <= W'(MISR_SEED);
        else if (en)
            sig <= {sig[W-2:0], (^(sig & W'(MISR_TAPS))) ^ din};
    end

endmodule

// File: rtl/scan_response_analyzer.sv
// Scan test sequencer: alternates chain shift/capture, compacts the response in a MISR, compares to golden.
// Optional abort input is enabled by defining SRA_ABORT_EN.
module scan_response_analyzer
    import sra_pkg::*;
#(
    parameter int CHAIN_LEN    = 8,
    parameter int NUM_PATTERNS = 16,
    parameter int SIG_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             scan_out,
    input  logic [SIG_W-1:0] golden_sig,
    output logic             scan_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
`ifdef SRA_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int SCW = $clog2(CHAIN_LEN + 1);
    localparam int PCW = $clog2(NUM_PATTERNS + 1);

    sra_state_e     state;
    logic [SCW-1:0] shift_cnt;
    logic [PCW-1:0] pat_cnt;
    logic           kill;
    logic           misr_clr;
    logic           misr_en;

`ifdef SRA_ABORT_EN
    assign kill = abort && busy;
`else
    assign kill = 1'b0;
`endif

    // busy is low exactly in IDLE/DONE, so this is the run-launch condition.
    assign misr_clr = start && !busy;
    assign misr_en  = (state == SHIFT) && !kill;

    sra_misr #(.W(SIG_W)) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr),
        .en  (misr_en),
        .din (scan_out),
        .sig (signature)
    );

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            state     <= IDLE;
            scan_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            shift_cnt <= '0;
            pat_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SHIFT;
                        scan_en   <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        shift_cnt <= '0;
                        pat_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (shift_cnt == SCW'(CHAIN_LEN - 1)) begin
                        shift_cnt <= '0;
                        scan_en   <= 1'b0;
                        // The shift following the last capture is the final unload.
                        state     <= (pat_cnt == PCW'(NUM_PATTERNS)) ? COMPARE : CAPTURE;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    state   <= SHIFT;
                    scan_en <= 1'b1;
                    pat_cnt <= pat_cnt + 1'b1;
                end
                COMPARE: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (signature == golden_sig);
                end
                default: begin
                    state   <= IDLE;
                    scan_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_response_analyzer.sv
// Randomized self-checking bench for scan_response_analyzer against a cycle-indexed run model.
module tb_scan_response_analyzer;

    localparam int RUN_CYC = 152;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       scan_out = 1'b0;
    logic [7:0] golden_sig = 8'h00;
    logic       scan_en, busy, done, pass;
    logic [7:0] signature;
`ifdef SRA_ABORT_EN
    logic       abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    bit stim [0:RUN_CYC-1];

    scan_response_analyzer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .scan_out   (scan_out),
        .golden_sig (golden_sig),
        .scan_en    (scan_en),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
`ifdef SRA_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] misr_step(input logic [7:0] s, input bit b);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ b};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".scan_en"}, scan_en, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".pass"}, pass, 0);
    endtask

    // Cycle c counts cycles after the start edge: 16 x (8 shifts + 1 capture), 8 shifts, 1 compare.
    task automatic run(input int rst_at, input int restart_at, input int abort_at);
        logic [7:0] m;
        bit exp_se;
        m = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= RUN_CYC; c++) begin
            if (c == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk_idle("rst_mid");
                chk("rst_mid.sig", signature, 8'h00);
                return;
            end
`ifdef SRA_ABORT_EN
            if (c == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                chk_idle("abort");
                chk("abort.sig", signature, m);
                return;
            end
`endif
            exp_se = (c < 144) ? ((c % 9) < 8) : (c < RUN_CYC);
            chk("scan_en", scan_en, exp_se);
            chk("busy", busy, 1);
            chk("done", done, 0);
            chk("pass_low", pass, 0);
            chk("sig_run", signature, m);
            start = (c == restart_at);
            scan_out = (c < RUN_CYC) ? stim[c] : 1'b0;
            if (exp_se) m = misr_step(m, stim[c]);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("end.done", done, 1);
        chk("end.busy", busy, 0);
        chk("end.scan_en", scan_en, 0);
        chk("end.sig", signature, m);
        chk("end.pass", pass, (m == golden_sig));
    endtask

    function automatic logic [7:0] model_sig();
        logic [7:0] m;
        m = 8'h00;
        for (int c = 0; c < RUN_CYC; c++)
            if (c >= 144 || (c % 9) < 8) m = misr_step(m, stim[c]);
        return m;
    endfunction

    task automatic fill(input int kind);
        for (int c = 0; c < RUN_CYC; c++)
            stim[c] = (kind == 0) ? 1'b0 : (kind == 1) ? (c == RUN_CYC - 1) : bit'($urandom_range(0, 1));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset.sig", signature, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle("idle");

        fill(0); golden_sig = 8'h00;
        run(-1, -1, -1);

        fill(1); golden_sig = 8'h01;
        run(-1, -1, -1);
        golden_sig = 8'h02;
        run(-1, -1, -1);

        for (int i = 0; i < 4; i++) begin
            fill(2);
            golden_sig = (i % 2 == 0) ? model_sig() : (model_sig() ^ 8'(1 << (i % 8)));
            run(-1, (i == 1) ? 20 : -1, -1);
        end

        fill(2); golden_sig = model_sig();
        run(50, -1, -1);
        run(-1, -1, -1);

`ifdef SRA_ABORT_EN
        fill(2); golden_sig = model_sig();
        run(-1, -1, 30);
        run(-1, -1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
